// File: rtl/pdec38_seq_pkg.sv
// Shared types and helpers for the sequenced 3:8 decoder.
package pdec_pkg;
  localparam int CODE_W = 3;
  localparam int LINES  = 1 << CODE_W;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} pdec_state_t;

  function automatic logic [LINES-1:0] onehot(input logic [CODE_W-1:0] code);
    onehot = '0;
    onehot[code] = 1'b1;
  endfunction
endpackage

// File: rtl/pdec38_seq_onehot.sv
// Combinational code -> one-hot line decode.
module pdec_onehot #(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0]      code,
  output logic [(1<<N_IN)-1:0] y
);
  import pdec_pkg::*;

  generate
    if (N_IN == CODE_W) begin : g_pkg
      assign y = onehot(code);
    end else begin : g_gen
      always_comb begin
        y = '0;
        y[code] = 1'b1;
      end
    end
  endgenerate
endmodule

// File: rtl/pdec38_seq.sv
// Sequenced 3:8 decoder: one-entry pending buffer feeding a HOLD/GAP pulse FSM.
module pdec38_seq #(
  parameter int N_IN = 3,
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in_code,
  input  logic [(1<<N_IN)-1:0] en_mask,
  output logic [(1<<N_IN)-1:0] y,
  output logic                 busy,
  output logic                 done,
  output logic                 drop
);
  import pdec_pkg::*;

  localparam int N_OUT = 1 << N_IN;
  localparam int CMAX  = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW    = $clog2((CMAX > 2) ? CMAX : 2);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? GAP - 1 : 0);

  pdec_state_t     state;
  logic [CW-1:0]   cnt;
  logic            pend_valid;
  logic [N_IN-1:0] pend_code;
  logic [N_OUT-1:0] dec;
  logic            cnt_zero;
  logic            take;

  pdec_onehot #(.N_IN(N_IN)) u_dec (.code(pend_code), .y(dec));

  assign in_ready = !rst && !pend_valid;
  assign busy     = (state != IDLE) || pend_valid;
  assign cnt_zero = (cnt == '0);

  // Points where the FSM consumes the pending register.
  always_comb begin
    take = 1'b0;
    case (state)
      IDLE:    take = pend_valid;
      DRIVE:   take = pend_valid && cnt_zero && (GAP == 0);
      default: take = pend_valid && cnt_zero;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_code  <= '0;
      y          <= '0;
      done       <= 1'b0;
      drop       <= 1'b0;
    end else begin
      done <= 1'b0;
      drop <= 1'b0;
      if (in_valid && in_ready) begin
        pend_valid <= 1'b1;
        pend_code  <= in_code;
      end
      case (state)
        DRIVE: begin
          if (!cnt_zero) begin
            cnt  <= cnt - 1'b1;
            done <= (cnt == CW'(1));
          end else if (GAP > 0) begin
            state <= pdec_pkg::GAP;
            y     <= '0;
            cnt   <= GAP_LD;
          end else begin
            state <= IDLE;
            y     <= '0;
          end
        end
        pdec_pkg::GAP: begin
          if (!cnt_zero) cnt <= cnt - 1'b1;
          else           state <= IDLE;
        end
        default: ;
      endcase
      // A load overrides the plain transitions above; the mask is checked only here.
      if (take) begin
        pend_valid <= 1'b0;
        if (en_mask[pend_code]) begin
          state <= DRIVE;
          y     <= dec;
          cnt   <= HOLD_LD;
          done  <= (HOLD == 1);
        end else begin
          state <= IDLE;
          y     <= '0;
          drop  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pdec38_seq.sv
// Scoreboard bench for pdec38_seq: default build plus a HOLD=1/GAP=0 build.
module tb_pdec38_seq;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, busy, done, drop;
  logic [2:0] in_code;
  logic [7:0] en_mask, y;
  logic       rst2, v2, rdy2, busy2, done2, drop2;
  logic [2:0] c2;
  logic [7:0] m2, y2;

  int nvec = 0, nerr = 0;
  logic [31:0] sb[$], sb2[$];
  logic [7:0]  ylog[$];
  logic [9:0]  log2[$];
  bit logging = 0, logging2 = 0;
  int ndrop = 0, pos = 0;
  logic [7:0] prev_y = '0;
  logic       prev_done = 1'b0;

  logic [7:0] ey [7] = '{8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
  logic       ed [7] = '{0, 0, 0, 0, 1, 0, 0};
  logic       eb [7] = '{1, 1, 1, 1, 1, 1, 0};
  logic       er [7] = '{0, 1, 1, 1, 1, 1, 1};
  logic [7:0] eb2 [15] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01, 8'h01, 8'h01,
                           8'h01, 8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
  logic [9:0] e5 [6] = '{10'h102, 10'h000, 10'h104, 10'h000, 10'h110, 10'h000};

  pdec38_seq #(.N_IN(3), .HOLD(HOLD), .GAP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .en_mask(en_mask), .y(y), .busy(busy), .done(done), .drop(drop));

  pdec38_seq #(.N_IN(3), .HOLD(1), .GAP(0)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(v2), .in_ready(rdy2), .in_code(c2),
    .en_mask(m2), .y(y2), .busy(busy2), .done(done2), .drop(drop2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse/drop monitor for the default build; expectations are {drop,y}.
  always @(negedge clk) begin
    if (logging) ylog.push_back(y);
    if (rst) begin
      prev_y = '0; prev_done = 1'b0; pos = 0;
    end else begin
      if (drop) begin
        ndrop++;
        if (sb.size() == 0) chk("drop_unexp", {drop, y}, 0);
        else chk("drop_sb", {drop, y}, sb.pop_front());
      end
      if (y != 0) begin
        if (prev_y == 0 || prev_done) begin
          pos = 0;
          if (sb.size() == 0) chk("pulse_unexp", {drop, y}, 0);
          else chk("pulse_sb", {drop, y}, sb.pop_front());
        end else pos++;
        chk("done_pos", done, 32'(pos == HOLD - 1));
      end else if (prev_y != 0) chk("pulse_end", prev_done, 1);
      prev_y = y;
      prev_done = done;
    end
  end

  always @(negedge clk) begin
    if (logging2) log2.push_back({drop2, done2, y2});
    if (!rst2 && y2 != 0) begin
      if (sb2.size() == 0) chk("p2_unexp", {drop2, done2, y2}, 0);
      else chk("p2_sb", {drop2, done2, y2}, sb2.pop_front());
    end
  end

  task automatic send(input logic [2:0] c);
    int t = 0;
    in_code = c; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin t++; @(negedge clk); end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 1);
    else sb.push_back(en_mask[c] ? 32'(8'd1 << c) : 32'h100);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic send2(input logic [2:0] c);
    int t = 0;
    c2 = c; v2 = 1'b1;
    @(negedge clk);
    while (!rdy2 && t < 50) begin t++; @(negedge clk); end
    if (!rdy2) chk("accept2_timeout", 32'(rdy2), 1);
    else sb2.push_back(32'h100 | 32'(8'd1 << c));
    @(posedge clk); #1 v2 = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((busy || y != 0) && t < 100) begin t++; @(negedge clk); end
    chk("idle", {busy, y}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0, nz;
    rst = 1'b1; in_valid = 1'b1; in_code = 3'd5; en_mask = 8'hFF;
    rst2 = 1'b1; v2 = 1'b0; c2 = '0; m2 = 8'hFF;

    // reset holds everything quiet even with in_valid high
    repeat (3) begin
      @(negedge clk);
      chk("rst_y", y, 0); chk("rst_rdy", in_ready, 0); chk("rst_busy", busy, 0);
    end
    @(posedge clk); #1 rst = 1'b0; rst2 = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_noacc", busy, 0); chk("rdy_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // single code, cycle-exact timing
    in_code = 3'd5; in_valid = 1'b1; sb.push_back(32'h20);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("t2_y", y, ey[k]); chk("t2_done", done, ed[k]);
      chk("t2_busy", busy, eb[k]); chk("t2_rdy", in_ready, er[k]);
      @(posedge clk); #1;
    end

    // back-to-back with a stalled third code
    ylog.delete(); logging = 1;
    send(3'd7); send(3'd0);
    in_code = 3'd3; in_valid = 1'b1;
    @(negedge clk); chk("stall_rdy", in_ready, 0);
    send(3'd3);
    wait_idle(); logging = 0;
    while (ylog.size() > 0 && ylog[0] == 0) void'(ylog.pop_front());
    for (int k = 0; k < 15; k++) chk("b2b_y", (ylog.size() > k) ? ylog[k] : 8'hEE, eb2[k]);

    // masked code is dropped, next code drives normally
    en_mask = 8'hF7; d0 = ndrop; ylog.delete(); logging = 1;
    send(3'd3); wait_idle(); logging = 0;
    chk("drop_cnt", ndrop - d0, 1);
    nz = 0;
    foreach (ylog[i]) if (ylog[i] != 0) nz++;
    chk("drop_y0", nz, 0);
    send(3'd2); wait_idle();

    // mask change mid-pulse has no effect on the active pulse
    en_mask = 8'hFF;
    send(3'd4);
    repeat (2) @(posedge clk);
    #1 en_mask = 8'h00;
    wait_idle(); en_mask = 8'hFF;
    chk("sb_drain", sb.size(), 0);

    // HOLD=1, GAP=0 build
    log2.delete(); logging2 = 1;
    send2(3'd1); send2(3'd2); send2(3'd4);
    repeat (4) @(posedge clk);
    #1 logging2 = 0;
    while (log2.size() > 0 && log2[0] == 0) void'(log2.pop_front());
    for (int k = 0; k < 6; k++) chk("t5_seq", (log2.size() > k) ? log2[k] : 10'h3FF, e5[k]);
    chk("sb2_drain", sb2.size(), 0);
    chk("busy2_idle", busy2, 0);

    // reset in the 2nd DRIVE cycle of code 6 with code 1 pending
    send(3'd6); send(3'd1);
    rst = 1'b1; sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_y", y, 0); chk("rstmid_rdy", in_ready, 1); chk("rstmid_busy", busy, 0);
    ylog.delete(); logging = 1;
    repeat (10) @(negedge clk);
    logging = 0;
    nz = 0;
    foreach (ylog[i]) if (ylog[i] != 0) nz++;
    chk("rstmid_quiet", nz, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
